// File: rtl/irq_ctrl.sv
// Interrupt controller: latches six sources into PEND, masks them and exposes PEND/MASK/ACK/ID registers.
// Define IRQ_CTRL_EDGE_EN for rising-edge latching; the default build latches on level.
module irq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  src,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] rdata,
   output logic [5:0]  hwint,
   output logic        irq
);

   localparam int unsigned NSRC    = 6;
   localparam int unsigned ID_W    = 3;
   localparam logic [31:0] BASE    = 32'h0000_7f40;
   localparam logic [1:0]  SEL_PEND = 2'd0;
   localparam logic [1:0]  SEL_MASK = 2'd1;
   localparam logic [1:0]  SEL_ACK  = 2'd2;
   localparam logic [1:0]  SEL_ID   = 2'd3;

   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] set_c;
   logic [NSRC-1:0] ack_clr_c;
   logic [ID_W-1:0] id_c;
   logic            in_win_c;
   logic            wr_en_c;
   logic [1:0]      reg_sel_c;
   logic            unused_bits;

   assign unused_bits = ^{wdata[31:NSRC], byteen[3:1], addr[1:0]};

   // Four-word window decoded on the word address only.
   assign in_win_c  = (addr[31:4] == BASE[31:4]);
   assign reg_sel_c = addr[3:2];
   assign wr_en_c   = byteen[0] & in_win_c;
   assign ack_clr_c = (wr_en_c && reg_sel_c == SEL_ACK) ? wdata[NSRC-1:0] : '0;

`ifdef IRQ_CTRL_EDGE_EN
   logic [NSRC-1:0] src_q;

   always_ff @(posedge clk) begin
      if (reset) src_q <= '0;
      else       src_q <= src;
   end

   assign set_c = src & ~src_q;
`else
   assign set_c = src;
`endif

   // Set is ORed in after the clear so a coincident set wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
         mask <= '0;
      end else begin
         pend <= (pend & ~ack_clr_c) | set_c;
         if (wr_en_c && reg_sel_c == SEL_MASK) mask <= wdata[NSRC-1:0];
      end
   end

   assign hwint = pend & mask;
   assign irq   = |hwint;

   // Lowest index wins, so scan from the top and let lower bits overwrite.
   always_comb begin
      id_c = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (hwint[i]) id_c = ID_W'(i + 1);
      end
   end

   always_comb begin
      rdata = '0;
      if (in_win_c) begin
         case (reg_sel_c)
            SEL_PEND: rdata[NSRC-1:0] = pend;
            SEL_MASK: rdata[NSRC-1:0] = mask;
            SEL_ID:   rdata[ID_W-1:0] = id_c;
            default:  rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic against a per-bit behavioural model.
// Follows IRQ_CTRL_EDGE_EN the same way the design does.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  src;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  byteen;
   logic [31:0] rdata;
   logic [5:0]  hwint;
   logic        irq;

   int checks = 0;
   int errors = 0;

`ifdef IRQ_CTRL_EDGE_EN
   localparam bit EDGE_MODE = 1'b1;
`else
   localparam bit EDGE_MODE = 1'b0;
`endif

   // Reference state
   logic [5:0] m_pend;
   logic [5:0] m_mask;
   logic [5:0] m_prev;

   irq_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .src    (src),
      .addr   (addr),
      .wdata  (wdata),
      .byteen (byteen),
      .rdata  (rdata),
      .hwint  (hwint),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int m_id();
      int id = 0;
      for (int i = 0; i < 6; i++) begin
         if (m_pend[i] && m_mask[i] && id == 0) id = i + 1;
      end
      return id;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int word;
      if ((a >> 4) != 32'h7f4) return 32'h0;
      word = int'(a[3:2]);
      if (word == 0) return {26'h0, m_pend};
      if (word == 1) return {26'h0, m_mask};
      if (word == 2) return 32'h0;
      return 32'(m_id());
   endfunction

   // Advance one clock and apply the register rules to the model using the inputs seen at the edge.
   task automatic tick();
      logic [5:0] np;
      logic [5:0] nm;
      bit wr;
      bit is_set;
      bit is_clr;
      @(posedge clk);
      np = m_pend;
      nm = m_mask;
      wr = byteen[0] && ((addr >> 4) == 32'h7f4);
      for (int i = 0; i < 6; i++) begin
         is_set = EDGE_MODE ? (src[i] && !m_prev[i]) : src[i];
         is_clr = wr && addr[3:2] == 2'd2 && wdata[i];
         if (is_set)      np[i] = 1'b1;
         else if (is_clr) np[i] = 1'b0;
      end
      if (wr && addr[3:2] == 2'd1) nm = wdata[5:0];
      if (reset) begin
         m_pend = 6'h0;
         m_mask = 6'h0;
         m_prev = 6'h0;
      end else begin
         m_pend = np;
         m_mask = nm;
         m_prev = src;
      end
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [5:0] exp_hw;
      exp_hw = m_pend & m_mask;
      check({tag, "_hwint"}, 32'(hwint), 32'(exp_hw));
      check({tag, "_irq"},   32'(irq),   32'(|exp_hw));
      check({tag, "_rdata"}, rdata,      m_read(addr));
   endtask

   task automatic step(input string tag);
      #1;
      check_all(tag);
      tick();
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr   = a;
      wdata  = d;
      byteen = be;
   endtask

   task automatic idle();
      bus(32'h0, 32'h0, 4'h0);
   endtask

   task automatic rd_const(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus(a, 32'h0, 4'h0);
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      src   = 6'h0;
      m_pend = 6'h0;
      m_mask = 6'h0;
      m_prev = 6'h0;
      idle();

      // Reset and first cycle after it
      do_reset();
      #1;
      check("rst_hwint", 32'(hwint), 32'h0);
      check("rst_irq",   32'(irq),   32'h0);

      // Single-cycle pulse on the external source
      bus(32'h7f44, 32'h3f, 4'h1);
      step("r27_mask");
      src = 6'h04;
      idle();
      step("r27_pulse");
      src = 6'h00;
      rd_const("r27_pend", 32'h7f40, 32'h4);
      check("r27_irq", 32'(irq), 32'h1);
      rd_const("r27_id", 32'h7f4c, 32'h3);
      step("r27_hold");

      // Masking and priority
      do_reset();
      bus(32'h7f44, 32'h04, 4'h1);
      src = 6'h06;
      step("r28_set");
      src = 6'h00;
      idle();
      step("r28_idle");
      rd_const("r28_id_a", 32'h7f4c, 32'h3);
      check("r28_hw_a", 32'(hwint), 32'h04);
      bus(32'h7f44, 32'h06, 4'h1);
      step("r28_mask");
      rd_const("r28_id_b", 32'h7f4c, 32'h2);
      check("r28_hw_b", 32'(hwint), 32'h06);

      // Coincident set and acknowledge on bit 2
      src = 6'h04;
      bus(32'h7f48, 32'h04, 4'h1);
      step("r29_race");
      src = 6'h00;
      rd_const("r29_pend", 32'h7f40, 32'h06);
      bus(32'h7f48, 32'h06, 4'h1);
      step("r29_ack");
      rd_const("r29_clear", 32'h7f40, 32'h00);

      // Held source with acknowledge mid-way
      do_reset();
      bus(32'h7f44, 32'h01, 4'h1);
      step("r30_mask");
      src = 6'h01;
      for (int c = 1; c <= 10; c++) begin
         if (c == 5) bus(32'h7f48, 32'h01, 4'h1);
         else        bus(32'h7f40, 32'h0, 4'h0);
         step("r30_hold");
         if (c == 6) begin
            #1;
            check("r30_pend0", 32'(rdata[0]), EDGE_MODE ? 32'h0 : 32'h1);
         end
      end
      src = 6'h00;

      // Ignored byte lanes and out-of-window reads
      bus(32'h7f44, 32'h3f, 4'h1);
      step("r31_mask");
      bus(32'h7f44, 32'h00, 4'b0010);
      step("r31_lane");
      rd_const("r31_mask_kept", 32'h7f44, 32'h3f);
      rd_const("r31_ack_rd",    32'h7f48, 32'h0);
      rd_const("r31_outside",   32'h7f50, 32'h0);
      rd_const("r31_low_bits",  32'h7f47, 32'h3f);

      // Reset discards pending state
      src = 6'h3f;
      idle();
      step("r32_fill");
      src = 6'h00;
      rd_const("r32_full", 32'h7f40, 32'h3f);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd_const("r32_pend", 32'h7f40, 32'h0);
      rd_const("r32_mask", 32'h7f44, 32'h0);
      check("r32_irq", 32'(irq), 32'h0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         int pick;
         pick = int'($urandom_range(0, 7));
         case (pick)
            0, 1, 2, 3: a = 32'h7f40 + 32'(pick * 4);
            4:          a = 32'h7f50;
            5:          a = 32'h7f3c;
            default:    a = $urandom;
         endcase
         a[1:0] = 2'($urandom);
         bus(a, $urandom, 4'($urandom));
         src   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
         reset = ($urandom_range(0, 63) == 0);
         step("rand");
      end
      reset = 1'b0;
      idle();
      step("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
